// File: rtl/cn_clk_div_pkg.sv
// rtl/cn_clk_div_pkg.sv - shared types and limits for the clock-enable generator
package cn_clk_div_pkg;

  localparam int MAX_CH    = 16;
  localparam int DEF_DIV_W = 8;

  typedef enum logic {SQUARE = 1'b0, PULSE = 1'b1} div_mode_e;

  typedef struct packed {
    logic [DEF_DIV_W-1:0] div;
    div_mode_e            mode;
  } ch_cfg_t;

endpackage

// File: rtl/cn_clk_div_ch.sv
// rtl/cn_clk_div_ch.sv - one divider channel: period counter, shadow config, waveform registers
module cn_clk_div_ch
  import cn_clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  div_mode_e        load_mode,
  input  logic             sync,
  output logic             pend,
  output logic             div_clk,
  output logic             div_stb,
  output logic             active
);

  logic [DIV_W-1:0] div_q, cnt_q, pend_div_q;
  div_mode_e        mode_q, pend_mode_q;
  logic             act_q, pend_q;

  logic [DIV_W-1:0] div_d, cnt_d, eff_div;
  div_mode_e        mode_d, eff_mode;
  logic             act_d, eff_vld, at_end, apply;
  logic [DIV_W:0]   half_d;
  logic             stb_d, clk_d;

  always_comb begin
    // A config arriving this cycle is treated as already pending so it can
    // land on a boundary or sync that coincides with its acceptance.
    eff_vld  = pend_q | load;
    eff_div  = pend_q ? pend_div_q : load_div;
    eff_mode = pend_q ? pend_mode_q : load_mode;
    at_end   = act_q && (cnt_q == div_q - 1'b1);
    apply    = eff_vld && (!act_q || at_end || sync);

    div_d  = div_q;
    mode_d = mode_q;
    act_d  = act_q;
    cnt_d  = '0;
    if (apply) begin
      div_d  = eff_div;
      mode_d = eff_mode;
      act_d  = (eff_div != '0);
    end else if (act_q && !(at_end || sync)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are registered from next-state so they line up with cnt_q.
    half_d = ({1'b0, div_d} + 1'b1) >> 1;
    stb_d  = act_d && (cnt_d == '0);
    clk_d  = act_d && ((mode_d == PULSE) ? (cnt_d == '0) : ({1'b0, cnt_d} < half_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      mode_q      <= SQUARE;
      cnt_q       <= '0;
      act_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_mode_q <= SQUARE;
      div_clk     <= 1'b0;
      div_stb     <= 1'b0;
    end else begin
      div_q   <= div_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      div_clk <= clk_d;
      div_stb <= stb_d;
      if (apply) begin
        pend_q <= 1'b0;
      end else if (load) begin
        pend_q      <= 1'b1;
        pend_div_q  <= load_div;
        pend_mode_q <= load_mode;
      end
    end
  end

  assign pend   = pend_q;
  assign active = act_q;

endmodule

// File: rtl/cn_clk_div_gen.sv
// rtl/cn_clk_div_gen.sv - multi-channel clock-enable generator: config decode, ready mux, sync fan-out
module cn_clk_div_gen
  import cn_clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_vld,
  output logic              cfg_rdy,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_stb,
  output logic [NUM_CH-1:0] active
);

  localparam int CH_SPAN = 1 << CH_W;

  logic [NUM_CH-1:0]  pend, ch_clk, ch_stb, ch_act;
  logic [CH_SPAN-1:0] pend_pad;
  logic               xfer;

  // Unpopulated indices read as never-pending, so out-of-range writes are
  // accepted and then match no channel.
  always_comb begin
    pend_pad             = '0;
    pend_pad[NUM_CH-1:0] = pend;
  end

  assign cfg_rdy = !rst && !pend_pad[cfg_ch];
  assign xfer    = cfg_vld && cfg_rdy;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cn_clk_div_ch #(.DIV_W(DIV_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (xfer && (cfg_ch == CH_W'(i))),
      .load_div  (cfg_div),
      .load_mode (div_mode_e'(cfg_mode)),
      .sync      (sync_req),
      .pend      (pend[i]),
      .div_clk   (ch_clk[i]),
      .div_stb   (ch_stb[i]),
      .active    (ch_act[i])
    );
  end

  assign div_clk = ch_clk & {NUM_CH{!rst}};
  assign div_stb = ch_stb & {NUM_CH{!rst}};
  assign active  = ch_act & {NUM_CH{!rst}};

endmodule

// File: tb/tb_cn_clk_div_gen.sv
// tb/tb_cn_clk_div_gen.sv - directed and random bench for cn_clk_div_gen against a behavioural model
module tb_cn_clk_div_gen;
  import cn_clk_div_pkg::*;

  localparam int NUM_CH = 5;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 3;

  logic              clk = 1'b0, rst = 1'b1;
  logic              cfg_vld = 1'b0, cfg_mode = 1'b0, sync_req = 1'b0;
  logic              cfg_rdy;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] div_clk, div_stb, active;

  int n_chk = 0, n_fail = 0;

  ch_cfg_t m_run[NUM_CH], m_shadow[NUM_CH];
  bit      m_pend[NUM_CH], m_act[NUM_CH];
  int      m_pos[NUM_CH];

  cn_clk_div_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .sync_req(sync_req),
    .div_clk(div_clk), .div_stb(div_stb), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One base-clock tick of the specified behaviour, phrased as period position.
  function automatic void model_step(input bit rs, input bit acc, input int ch, input ch_cfg_t req, input bit sy);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rs) begin
        m_run[c] = '0; m_shadow[c] = '0; m_pend[c] = 0; m_act[c] = 0; m_pos[c] = 0;
      end else begin
        bit      mine     = acc && (ch == c);
        bit      have_cfg = m_pend[c] || mine;
        ch_cfg_t next_cfg = m_pend[c] ? m_shadow[c] : req;
        bit      last     = m_act[c] && (m_pos[c] == int'(m_run[c].div) - 1);
        if (have_cfg && (!m_act[c] || last || sy)) begin
          m_run[c]  = next_cfg;
          m_act[c]  = (next_cfg.div != 0);
          m_pos[c]  = 0;
          m_pend[c] = 0;
        end else begin
          if (mine) begin
            m_pend[c]   = 1;
            m_shadow[c] = req;
          end
          if (m_act[c]) m_pos[c] = sy ? 0 : (m_pos[c] + 1) % int'(m_run[c].div);
        end
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] exp_vec(input int which);
    logic [NUM_CH-1:0] v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int n = int'(m_run[c].div);
      bit first = (m_pos[c] == 0);
      case (which)
        0: v[c] = m_act[c] && ((m_run[c].mode == PULSE) ? first : (m_pos[c] < (n + 1) / 2));
        1: v[c] = m_act[c] && first;
        default: v[c] = m_act[c];
      endcase
    end
    return v;
  endfunction

  task automatic cycle(input bit vld, input int ch, input int dv, input bit md, input bit sy,
                       input bit rs, output bit rdy_seen);
    ch_cfg_t req;
    bit      exp_rdy;
    rst = rs; cfg_vld = vld; cfg_ch = ch[CH_W-1:0]; cfg_div = dv[DIV_W-1:0];
    cfg_mode = md; sync_req = sy;
    #1;
    exp_rdy = !rs && !((ch < NUM_CH) ? m_pend[ch] : 1'b0);
    check_eq("cfg_rdy", cfg_rdy, exp_rdy);
    if (rs) check_eq("rst_outputs", {div_clk, div_stb, active}, 0);
    rdy_seen = cfg_rdy;
    req.div  = dv[DIV_W-1:0];
    req.mode = div_mode_e'(md);
    @(posedge clk);
    model_step(rs, vld && exp_rdy, ch, req, sy);
    @(negedge clk);
    check_eq("div_clk", div_clk, exp_vec(0));
    check_eq("div_stb", div_stb, exp_vec(1));
    check_eq("active", active, exp_vec(2));
  endtask

  task automatic idle();
    bit r;
    cycle(0, 0, 0, 0, 0, 0, r);
  endtask

  task automatic cfg(input int ch, input int dv, input bit md);
    bit r;
    cycle(1, ch, dv, md, 0, 0, r);
  endtask

  task automatic wait_pos(input int ch, input int dv, input int pos);
    int n = 0;
    while (!(m_act[ch] && int'(m_run[ch].div) == dv && m_pos[ch] == pos) && n < 60) begin
      idle();
      n++;
    end
    check_eq("wait_pos_in_budget", n < 60, 1);
  endtask

  initial begin
    bit r;
    int lows;

    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = '0; m_shadow[c] = '0; m_pend[c] = 0; m_act[c] = 0; m_pos[c] = 0;
    end

    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 1, r);
    for (int i = 0; i < 8; i++) begin
      cycle(0, i, 0, 0, 0, 0, r);
      check_eq("rdy_after_reset", r, 1);
    end

    // N=4 SQUARE on an idle channel starts at once: 1,1,0,0
    cfg(0, 4, 0);
    check_eq("ch0_active_t1", active[0], 1);
    check_eq("ch0_stb_t1", div_stb[0], 1);
    for (int k = 0; k < 8; k++) begin
      check_eq("ch0_n4_clk", div_clk[0], (k % 4) < 2);
      check_eq("ch0_n4_stb", div_stb[0], (k % 4) == 0);
      idle();
    end

    // N=5 SQUARE: 3 high, 2 low; N=1 SQUARE constant high
    cfg(1, 5, 0);
    check_eq("ch1_n5_clk", div_clk[1], 1);
    cfg(2, 1, 0);
    for (int k = 1; k < 10; k++) begin
      check_eq("ch1_n5_clk", div_clk[1], (k % 5) < 3);
      check_eq("ch2_n1_sq", div_clk[2], 1);
      idle();
    end
    cfg(2, 1, 1);
    for (int k = 0; k < 3; k++) begin
      check_eq("ch2_n1_pulse", {div_clk[2], div_stb[2]}, 2'b11);
      idle();
    end

    // Reconfigure mid-period: old period completes, second write stalls
    cfg(0, 8, 0);
    wait_pos(0, 8, 2);
    cfg(0, 3, 1);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(k == 0, 0, 7, 0, 0, 0, r);
      if (r) break;
      lows++;
    end
    check_eq("rdy_low_cycles", lows, 5);
    for (int k = 0; k < 6; k++) begin
      check_eq("ch0_n3_pulse", div_clk[0], ((k + 1) % 3) == 0);
      idle();
    end

    // Out-of-phase channels realigned by sync_req
    cfg(0, 6, 0);
    cfg(3, 10, 0);
    for (int k = 0; k < 7; k++) idle();
    cycle(0, 0, 0, 0, 1, 0, r);
    check_eq("sync_stb", {div_stb[3], div_stb[0]}, 2'b11);
    for (int k = 0; k < 30; k++) idle();
    check_eq("sync_realign_30", {div_stb[3], div_stb[0]}, 2'b11);

    // Config on the last period cycle together with sync_req, then disable
    wait_pos(0, 6, 5);
    cycle(1, 0, 4, 0, 1, 0, r);
    check_eq("end_sync_apply", div_stb[0], 1);
    for (int k = 0; k < 4; k++) idle();
    check_eq("new_div4_stb", div_stb[0], 1);
    cfg(0, 0, 0);
    lows = 0;
    while (active[0] && lows < 10) begin
      idle();
      lows++;
    end
    check_eq("disable_in_budget", active[0], 0);
    check_eq("disabled_outputs", {div_clk[0], div_stb[0]}, 0);
    cfg(0, 0, 0);

    // Reset while a config is pending
    cfg(3, 2, 0);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 3, 0, 0, 0, 1, r);
      check_eq("rst_active", active, 0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, i, 0, 0, 0, 0, r);
      check_eq("rdy_after_midrst", r, 1);
      check_eq("active_after_midrst", active, 0);
    end

    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 9),
            $urandom_range(0, 1), $urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
